ifu_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer feeding the IF/ID pipeline register. Holds the program counter, issues one instruction read at a time on the instruction bus using a req/gnt/rvalid handshake, buffers the returned word, and presents it with its address to IF/ID. It requests a pipeline hold whenever no valid instruction is available. On a jump it redirects the PC and discards any in-flight response.

---
 rtl/tinyriscv_pkg.sv | 23 ++
 rtl/ifu_fetch_ctrl.sv | 83 ++++++++
 tb/tb_ifu_fetch_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: shared bus types, hold levels and fetch constants
package tinyriscv_pkg;

   typedef logic [31:0] InstBus;
   typedef logic [31:0] InstAddrBus;
   typedef logic [2:0]  Hold_Flag_Bus;

   localparam Hold_Flag_Bus Hold_None = 3'b000;
   localparam Hold_Flag_Bus Hold_Pc   = 3'b001;
   localparam Hold_Flag_Bus Hold_If   = 3'b010;
   localparam Hold_Flag_Bus Hold_Id   = 3'b011;

   localparam InstBus     INST_NOP     = 32'h0000_0001;
   localparam InstAddrBus ZeroWord     = 32'h0000_0000;
   localparam InstAddrBus CpuResetAddr = 32'h0000_0000;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: PC, single-outstanding instruction fetch and 1-entry buffer feeding IF/ID
module ifu_fetch_ctrl
   import tinyriscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        hold_req_o
);

   fetch_state_e r_state;
   InstAddrBus   r_pc;
   InstAddrBus   r_inflight_addr;
   InstAddrBus   r_buf_addr;
   InstBus       r_buf_inst;
   logic         r_buf_valid;
   logic         w_hold_en;
   logic         w_req;
   logic         w_consume;
   logic         w_unused;

   assign w_unused = ^jump_addr_i[1:0];

   // request only with an empty buffer or one that IF/ID drains this edge
   always_comb begin
      w_hold_en   = hold_flag_i >= Hold_If;
      w_consume   = r_buf_valid && !w_hold_en;
      w_req       = !rst && (r_state == REQ) && (!r_buf_valid || !w_hold_en);
      ibus_req_o  = w_req;
      ibus_addr_o = r_pc;
      inst_o      = r_buf_valid ? r_buf_inst : INST_NOP;
      inst_addr_o = r_buf_valid ? r_buf_addr : ZeroWord;
      hold_req_o  = !r_buf_valid;
   end

   // fetch FSM, PC and buffer; a jump overrides everything except reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= REQ;
         r_pc            <= CpuResetAddr;
         r_buf_valid     <= 1'b0;
         r_buf_inst      <= INST_NOP;
         r_buf_addr      <= ZeroWord;
         r_inflight_addr <= ZeroWord;
      end else if (jump_flag_i) begin
         r_pc        <= {jump_addr_i[31:2], 2'b00};
         r_buf_valid <= 1'b0;
         if (r_state == REQ)
            r_state <= (w_req && ibus_gnt_i) ? DISCARD : REQ;
         else
            r_state <= ibus_rvalid_i ? REQ : DISCARD;
      end else begin
         if (w_consume)
            r_buf_valid <= 1'b0;
         case (r_state)
            REQ: if (w_req && ibus_gnt_i) begin
               r_inflight_addr <= r_pc;
               r_state         <= WAIT;
            end
            WAIT: if (ibus_rvalid_i) begin
               r_buf_inst  <= ibus_rdata_i;
               r_buf_addr  <= r_inflight_addr;
               r_buf_valid <= 1'b1;
               r_pc        <= r_pc + 32'd4;
               r_state     <= REQ;
            end
            DISCARD: if (ibus_rvalid_i)
               r_state <= REQ;
            default: r_state <= REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed and random fetch traffic checked against a transaction-level model
module tb_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = '0;
   logic [2:0]  hold_flag_i = '0;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i = 1'b0;
   logic        ibus_rvalid_i = 1'b0;
   logic [31:0] ibus_rdata_i = '0;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        hold_req_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_pc = '0, m_bi = '0, m_ba = '0, m_oa = '0;
   logic        m_bv = 1'b0, m_out = 1'b0, m_drop = 1'b0;

   localparam logic [31:0] NOP = 32'h0000_0001;

   ifu_fetch_ctrl dut (
      .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .hold_flag_i(hold_flag_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
      .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .hold_req_o(hold_req_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_rq(input logic r, input logic [2:0] h);
      return !r && !m_out && (!m_bv || h < 3'd2);
   endfunction

   task automatic step(input logic r, input logic j, input logic [31:0] ja, input logic [2:0] h,
                       input logic g, input logic rv, input logic [31:0] rd);
      logic rq, cons;
      @(negedge clk);
      rst = r; jump_flag_i = j; jump_addr_i = ja; hold_flag_i = h;
      ibus_gnt_i = g; ibus_rvalid_i = rv; ibus_rdata_i = rd;
      rq   = m_rq(r, h);
      cons = m_bv && h < 3'd2;
      #1;
      chk("req", 32'(ibus_req_o), 32'(rq));
      if (rq) chk("addr", ibus_addr_o, m_pc);
      chk("inst", inst_o, m_bv ? m_bi : NOP);
      chk("inst_addr", inst_addr_o, m_bv ? m_ba : 32'h0);
      chk("hold_req", 32'(hold_req_o), 32'(!m_bv));
      @(posedge clk);
      if (r) begin
         m_pc = '0; m_bv = 0; m_out = 0; m_drop = 0;
      end else if (j) begin
         m_pc = {ja[31:2], 2'b00};
         m_bv = 0;
         if (rq && g) begin m_out = 1; m_drop = 1; end
         else if (m_out) begin
            if (rv) m_out = 0;
            else m_drop = 1;
         end
      end else begin
         if (cons) m_bv = 0;
         if (m_out && rv) begin
            if (!m_drop) begin m_bv = 1; m_bi = rd; m_ba = m_oa; m_pc = m_pc + 32'd4; end
            m_out = 0;
         end else if (rq && g) begin
            m_out = 1; m_drop = 0; m_oa = m_pc;
         end
      end
   endtask

   initial begin
      logic        bpend, j, rv, g;
      logic [31:0] baddr, ja, pre_pc;
      logic [2:0]  h;
      int          bcnt;
      bpend = 0; baddr = '0; bcnt = 0;
      repeat (2) @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_req", 32'(ibus_req_o), 32'h0);
      chk("rst_addr", ibus_addr_o, 32'h0);
      // first fetch on a zero-wait bus
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0093);
      #1;
      chk("t1_inst", inst_o, 32'h0000_0093);
      chk("t1_iaddr", inst_addr_o, 32'h0);
      chk("t1_next_addr", ibus_addr_o, 32'h4);
      // hold with a full buffer
      repeat (5) step(0, 0, 0, 3'd2, 0, 0, 0);
      #1;
      chk("hold_inst", inst_o, 32'h0000_0093);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0013);
      // jump coinciding with grant of 0x8
      step(0, 1, 32'h203, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
      #1;
      chk("jg_addr", ibus_addr_o, 32'h200);
      chk("jg_req", 32'(ibus_req_o), 32'h1);
      chk("jg_inst", inst_o, NOP);
      step(0, 0, 0, 0, 1, 0, 0);
      // jump while waiting for data
      step(0, 1, 32'h100, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
      #1;
      chk("jw_addr", ibus_addr_o, 32'h100);
      chk("jw_iaddr", inst_addr_o, 32'h0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0113);
      // slow grant and slow response
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'hCAFE_0001);
      #1;
      chk("slow_inst", inst_o, 32'hCAFE_0001);
      chk("slow_iaddr", inst_addr_o, 32'h104);
      // PC wrap-around
      step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1, 32'h0000_0513);
      #1;
      chk("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);
      chk("wrap_addr", ibus_addr_o, 32'h0);
      // reset in the middle of a transaction
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("mrst_inst", inst_o, NOP);
      chk("mrst_iaddr", inst_addr_o, 32'h0);
      chk("mrst_hreq", 32'(hold_req_o), 32'h1);
      step(0, 0, 0, 0, 0, 0, 0);
      // random traffic against a behavioural bus
      for (int i = 0; i < 600; i++) begin
         j  = ($urandom % 16) == 0;
         ja = $urandom;
         h  = ($urandom % 4 == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
         rv = bpend && bcnt == 0;
         g  = !bpend && m_rq(1'b0, h) && ($urandom % 2 == 1);
         pre_pc = m_pc;
         step(0, j, ja, h, g, rv, rv ? {baddr[15:0], ~baddr[15:0]} : $urandom);
         if (rv) bpend = 0;
         else if (bpend) bcnt--;
         if (g) begin bpend = 1; baddr = pre_pc; bcnt = $urandom % 3; end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
